// File: rtl/fetch_unit_pkg.sv
// Shared RV32 front-end types: instruction formats, fetch FSM states
// and fetch constants.
package fetch_unit_pkg;

    localparam int          OPCODE_W     = 7;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]          funct7;
        logic [4:0]          rs2;
        logic [4:0]          rs1;
        logic [2:0]          funct3;
        logic [4:0]          rd;
        logic [OPCODE_W-1:0] opcode;
    } rtype_t;

    typedef struct packed {
        logic [11:0]         imm;
        logic [4:0]          rs1;
        logic [2:0]          funct3;
        logic [4:0]          rd;
        logic [OPCODE_W-1:0] opcode;
    } itype_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over a same-cycle push/pop.
// Output is read straight from the storage registers.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop & (cnt != '0);
    assign do_push  = push & ~flush & ((cnt != CW'(DEPTH)) | do_pop);
    assign pop_data = mem[rp];
    assign count    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= push_data;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, imem request/response tracking, instr FIFO.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect halts with fetch_fault.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t  state, state_next;
    logic [31:0]   pc, pc_next;
    logic [CW-1:0] inflight, inflight_next;
    logic [CW-1:0] discard, discard_next;
    logic [CW-1:0] fifo_count, tag_count;
    logic          fault, fault_next;
    logic          hs, pop, push, misalign;
    logic [31:0]   tgt, tag_pc;
    logic [63:0]   head;
    logic [OW-1:0] occ;

    assign hs   = imem_req_valid & imem_req_ready;
    assign pop  = instr_valid & instr_ready;
    assign push = imem_rsp_valid & (discard == '0) & ~redirect_valid;
    assign tgt  = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    logic unused_ok;
    assign unused_ok = ^redirect_pc[1:0];
    assign misalign  = 1'b0;
`endif

    // A pop this cycle frees a slot, keeping one request per cycle in flow.
    assign occ = OW'(inflight) + OW'(fifo_count) - OW'(pop);
    assign imem_req_valid = (state == RUN) && (occ < OW'(DEPTH));
    assign imem_req_addr  = pc;
    assign instr_valid    = (fifo_count != '0) && (state != HALT);
    assign instr          = head[63:32];
    assign instr_pc       = head[31:0];
    assign fetch_fault    = fault;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        inflight_next = inflight + CW'(hs) - CW'(imem_rsp_valid);
        discard_next  = discard;
        fault_next    = fault;
        if (hs) pc_next = pc + 32'd4;
        if (imem_rsp_valid && discard != '0) discard_next = discard - CW'(1);
        unique case (state)
            BOOT:  state_next = RUN;
            RUN:   state_next = RUN;
            DRAIN: if (discard_next == '0) state_next = RUN;
            HALT:  state_next = HALT;
        endcase
        // Everything still outstanding after this edge belongs to old flow.
        if (redirect_valid) begin
            pc_next      = tgt;
            discard_next = inflight_next;
            fault_next   = misalign;
            if (misalign) state_next = HALT;
            else if (inflight_next != '0) state_next = DRAIN;
            else state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= inflight_next;
            discard  <= discard_next;
            fault    <= fault_next;
        end
    end

    fetch_fifo #(
        .WIDTH(64),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({imem_rsp_data, tag_pc}),
        .pop      (pop),
        .flush    (redirect_valid),
        .pop_data (head),
        .count    (fifo_count)
    );

    // Request addresses, one per outstanding request; never flushed.
    fetch_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (hs),
        .push_data(pc),
        .pop      (imem_rsp_valid),
        .flush    (1'b0),
        .pop_data (tag_pc),
        .count    (tag_count)
    );

    assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> inflight != '0);
    assert property (@(posedge clk) disable iff (!rst_n)
        inflight <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order imem model.
// Runs in both FETCH_ALIGN_CHECK_EN configurations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    bit rsp_en;

    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    int          got_cyc[$];

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step();
        if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            hs_cnt++;
        end
        if (instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            got_ins.push_back(instr);
            got_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int from,
                             input logic [31:0] base, input int n);
        check({tag, "_len"}, 32'(got_pc.size() >= from + n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (from + i < got_pc.size()) begin
                check($sformatf("%s_pc%0d", tag, i), got_pc[from+i],
                      base + 32'(4 * i));
                check($sformatf("%s_ins%0d", tag, i), got_ins[from+i],
                      memw(base + 32'(4 * i)));
            end
        end
    endtask

    initial begin
        int n_pre, n2, n3, n4, h;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        rsp_en         = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        rst_n = 1'b1;
        #1;
        check("boot_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        cyc++;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Sequential streaming, single-cycle memory.
        repeat (10) step();
        check_seq("seq", 0, 32'h0, 4);
        if (got_cyc.size() >= 4)
            check("seq_back2back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);

        // Decode backpressure.
        instr_ready = 1'b0;
        repeat (5) step();
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_instr_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        repeat (6) step();

        // Stall memory so two requests sit in flight, then redirect.
        rsp_en = 1'b0;
        repeat (4) step();
        check("c_full_req", 32'(imem_req_valid), 32'd0);
        check("c_fifo_empty", 32'(instr_valid), 32'd0);
        n_pre = got_pc.size();
        check_seq("prefix", 0, 32'h0, n_pre);
        redirect(32'h0000_0100);
        h = hs_cnt;
        repeat (3) step();
        check("drain_req_valid", 32'(imem_req_valid), 32'd0);
        rsp_en = 1'b1;
        repeat (2) step();
        check("drain_no_hs", 32'(hs_cnt - h), 32'd0);
        check("drain_no_instr", 32'(got_pc.size() - n_pre), 32'd0);
        check("post_drain_req", 32'(imem_req_valid), 32'd1);
        check("post_drain_addr", imem_req_addr, 32'h0000_0100);
        repeat (8) step();
        check_seq("redir100", n_pre, 32'h0000_0100, 3);

        // Redirect colliding with a pop and a response.
        check("d_valid_before", 32'(instr_valid), 32'd1);
        redirect(32'h0000_0300);
        check("d_fifo_empty", 32'(instr_valid), 32'd0);
        n2 = got_pc.size();
        check_seq("d_prefix", n_pre, 32'h0000_0100, n2 - n_pre);
        repeat (8) step();
        check_seq("redir300", n2, 32'h0000_0300, 3);

        // PC wrap-around.
        redirect(32'hFFFF_FFF8);
        n3 = got_pc.size();
        repeat (10) step();
        check_seq("wrap", n3, 32'hFFFF_FFF8, 4);

        // Misaligned redirect.
        redirect(32'h0000_0102);
        n4 = got_pc.size();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", 32'(fetch_fault), 32'd1);
        h = hs_cnt;
        repeat (6) step();
        check("halt_fault", 32'(fetch_fault), 32'd1);
        check("halt_req_valid", 32'(imem_req_valid), 32'd0);
        check("halt_instr_valid", 32'(instr_valid), 32'd0);
        check("halt_no_hs", 32'(hs_cnt - h), 32'd0);
        check("halt_no_instr", 32'(got_pc.size() - n4), 32'd0);
        redirect(32'h0000_0200);
        check("unhalt_fault", 32'(fetch_fault), 32'd0);
        n4 = got_pc.size();
        repeat (8) step();
        check_seq("redir200", n4, 32'h0000_0200, 3);
`else
        check("mis_fault", 32'(fetch_fault), 32'd0);
        repeat (8) step();
        check_seq("mis100", n4, 32'h0000_0100, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
